ysyx_22050078_ifu_fetch: RTL

Instruction fetch unit for the single-cycle/multicycle ysyx_22050078 core. It is the producing end of the instruction/PC interface that the decode stage consumes.
- Holds the PC.
- Issues fetch requests to instruction memory over a valid/ready request channel and a valid-only response channel.
- Presents the 32-bit instruction plus its PC to decode through a valid/ready handshake.
- Accepts PC redirects from execute for jumps and branches.

---
 rtl/ysyx_22050078_ifu_fetch.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ysyx_22050078_ifu_fetch.sv
// ysyx_22050078_ifu_fetch
// Instruction fetch unit: owns the PC, fetches one instruction at a time from
// instruction memory and hands it (with its PC) to decode.
//
// Ports:
//   clk, rst_n                 core clock (rising edge), async active-low reset
//   redirect_valid/redirect_pc PC change from execute; redirect_pc[1:0] ignored
//   imem_req_*                 request channel to imem (valid/ready), address = pc
//   imem_rsp_*                 response channel from imem (valid only, always accepted)
//   inst_valid/inst_ready      handshake to decode
//   inst_out, pc_out           instruction and its PC, held until accepted
//   fetch_err                  access fault of inst_out, qualified by inst_valid
//   perf_fetch_cnt             delivered-instruction counter (optional)
//
// Optional feature: define YSYX_22050078_IFU_PERF_EN to add perf_fetch_cnt.
module ysyx_22050078_ifu_fetch #(
    parameter int unsigned          PC_WIDTH   = 64,
    parameter int unsigned          INST_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC   = PC_WIDTH'(64'h0000_0000_8000_0000)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    redirect_valid,
    input  logic [PC_WIDTH-1:0]     redirect_pc,
    output logic                    imem_req_valid,
    input  logic                    imem_req_ready,
    output logic [PC_WIDTH-1:0]     imem_req_addr,
    input  logic                    imem_rsp_valid,
    input  logic [INST_WIDTH-1:0]   imem_rsp_data,
    input  logic                    imem_rsp_err,
    output logic                    inst_valid,
    input  logic                    inst_ready,
    output logic [INST_WIDTH-1:0]   inst_out,
    output logic [PC_WIDTH-1:0]     pc_out,
    output logic                    fetch_err
`ifdef YSYX_22050078_IFU_PERF_EN
    ,
    output logic [63:0]             perf_fetch_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_OUT,
        S_DROP
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [PC_WIDTH-1:0]    pc;
    logic                   req_fire;
    logic                   inst_fire;
    logic                   redirect_pc_unused;

    // Low address bits of a redirect target are forced to zero.
    assign redirect_pc_unused = ^redirect_pc[1:0];

    assign req_fire  = imem_req_valid & imem_req_ready;
    assign inst_fire = inst_valid & inst_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a redirect takes priority over every other transition.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: state_next = S_REQ;
            S_REQ: begin
                if (redirect_valid) begin
                    // An already-accepted request must still have its response drained.
                    state_next = req_fire ? S_DROP : S_REQ;
                end else if (req_fire) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    state_next = imem_rsp_valid ? S_REQ : S_DROP;
                end else if (imem_rsp_valid) begin
                    state_next = S_OUT;
                end
            end
            S_OUT: begin
                if (redirect_valid || inst_ready) begin
                    state_next = S_REQ;
                end
            end
            S_DROP: begin
                // A response arriving alongside a redirect still retires the
                // outstanding request, so there is nothing left to wait for.
                if (imem_rsp_valid) begin
                    state_next = S_REQ;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs decoded from the registered state only
    always_comb begin
        imem_req_valid = (state == S_REQ);
        inst_valid     = (state == S_OUT);
        imem_req_addr  = pc;
    end

    // PC and decode-side holding registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            inst_out  <= '0;
            pc_out    <= '0;
            fetch_err <= 1'b0;
        end else begin
            if (redirect_valid) begin
                pc <= {redirect_pc[PC_WIDTH-1:2], 2'b00};
            end else if (inst_fire) begin
                pc <= pc + PC_WIDTH'(4);
            end

            if ((state == S_WAIT) && imem_rsp_valid && !redirect_valid) begin
                inst_out  <= imem_rsp_data;
                pc_out    <= pc;
                fetch_err <= imem_rsp_err;
            end
        end
    end

`ifdef YSYX_22050078_IFU_PERF_EN
    // Counts instructions actually consumed by decode; cancelled ones excluded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
        end else if (inst_fire && !redirect_valid) begin
            perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
        end
    end
`endif

endmodule
